// File: rtl/ibuf_hl_pkg.sv
// Shared flit definitions for the input buffer: data width, field positions
// and flit-type encodings used by the buffer and by anything decoding flits.
package ibuf_hl_pkg;

  // Flit is [DATAW:0]; the type field sits in the top two bits,
  // the virtual-channel field directly below it.
  localparam int DATAW   = 15;
  localparam int TYPE_HI = DATAW;
  localparam int TYPE_LO = DATAW - 1;
  localparam int VCH_HI  = DATAW - 2;
  localparam int VCH_LO  = DATAW - 3;

  typedef enum logic [1:0] {
    FT_HEAD     = 2'b00,
    FT_BODY     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  function automatic logic is_head_type(input logic [1:0] t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  function automatic logic is_tail_type(input logic [1:0] t);
    return (t == FT_TAIL) || (t == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/fifo_mem_hl.sv
// Storage array for the input buffer: one synchronous write port and one
// asynchronous read port so the front flit falls through combinationally.
module fifo_mem_hl #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTRW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTRW-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ibuf_hl.sv
// Router input buffer: FWFT flit FIFO plus a two-state packet FSM that
// requests route computation for each head flit, forwards on grant, and
// discards stray body/tail flits that arrive with no routed packet.
//
// state     | meaning
// ST_IDLE   | no packet routed; head at front triggers rc_en
// ST_ACTIVE | packet routed; grant pops flits until the tail
module ibuf_hl
  import ibuf_hl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [DATAW:0] idata,
  input  logic           ivalid,
  input  logic           grant,
  output logic [DATAW:0] odata,
  output logic           ovalid,
  output logic           rc_en,
  output logic           ocredit,
  output logic [PTRW:0]  count,
  output logic           full,
  output logic           err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            ocredit_q, ocredit_d;
  logic            err_q, err_d;

  logic [1:0] front_type;
  logic       front_head, front_tail;
  logic       pop, discard, wr_en, overflow, mem_we;

  fifo_mem_hl #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW),
    .WIDTH (DATAW + 1)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (idata),
    .raddr (rd_ptr_q),
    .rdata (odata)
  );

  assign front_type = odata[TYPE_HI:TYPE_LO];
  assign front_head = is_head_type(front_type);
  assign front_tail = is_tail_type(front_type);
  assign ovalid     = (count_q != '0);
  assign full       = (count_q == (PTRW+1)'(DEPTH));
  assign count      = count_q;
  assign ocredit    = ocredit_q;
  assign err        = err_q;

  // State, pointer, occupancy and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ocredit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ocredit_q <= ocredit_d;
      err_q     <= err_d;
    end
  end

  // Next-state: head at front gets routed; popping a tail ends the packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ovalid && front_head) state_d = ST_ACTIVE;
      ST_ACTIVE: if (pop && front_tail)    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant only matters once the packet is routed; a non-head
  // at the front while idle is an orphan and is dropped immediately.
  always_comb begin
    rc_en   = 1'b0;
    pop     = 1'b0;
    discard = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ovalid) begin
          if (front_head) begin
            rc_en = 1'b1;
          end else begin
            pop     = 1'b1;
            discard = 1'b1;
          end
        end
      end
      ST_ACTIVE: pop = grant && ovalid;
      default: ;
    endcase
  end

  // Datapath: a same-cycle pop frees the slot, so a full FIFO still accepts.
  always_comb begin
    wr_en    = ivalid && (!full || pop);
    overflow = ivalid && full && !pop;
    mem_we   = wr_en && !rst_;
    wr_ptr_d = wr_en ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTRW+1)'(1);
      2'b01:   count_d = count_q - (PTRW+1)'(1);
      default: count_d = count_q;
    endcase
    ocredit_d = pop;
    err_d     = err_q || overflow || discard;
  end

endmodule
